adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Round-robin arbiter that shares one Adder stream datapath (32-bit val/rdy in, val/rdy out, result = input + 1) among NUM_REQ requester streams.
- Grants one requester at a time and forwards its request word to the adder.
- Routes the adder result back to the same requester, then rotates priority.
- Sits between the requester-side stream interfaces and the single adder instance. Exactly one transaction is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- DATA_W, 32, stream data width; must match the adder.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  per-requester request ready.
- req_data  in  NUM_REQ*DATA_W  request words; requester i occupies bits [i*DATA_W +: DATA_W].
- resp_val  out  NUM_REQ  per-requester response valid.
- resp_rdy  in  NUM_REQ  per-requester response ready.
- resp_data  out  DATA_W  response word, broadcast to all requesters; qualified by resp_val[i].
- adder_i_val  out  1  to adder i_stream_val.
- adder_i_rdy  in  1  from adder i_stream_rdy.
- adder_i_data  out  DATA_W  to adder i_stream_data.
- adder_o_val  in  1  from adder o_stream_val.
- adder_o_rdy  out  1  to adder o_stream_rdy.
- adder_o_data  in  DATA_W  from adder o_stream_data.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester (registered).
- busy  out  1  high when state is not IDLE.
- done_count  out  CNT_W  number of completed response handshakes.

Behaviour:
- States: IDLE, SEND, WAIT. State, grant_id, rr_ptr and done_count are registered.
- Reset (synchronous, takes priority in every state; aborts any transaction):
  - state=IDLE, grant_id=0, rr_ptr=0, done_count=0.
  - All outputs: req_rdy=0, resp_val=0, adder_i_val=0, adder_o_rdy=0, busy=0, resp_data=adder_o_data, adder_i_data=0.
  - The adder shares this reset.
- IDLE:
  - All handshake outputs are 0.
  - If any req_val is set, grant the first set bit found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index into grant_id and go to SEND. Otherwise stay in IDLE.
  - The grant decision is made from req_val sampled in this cycle.
- SEND (g = grant_id):
  - adder_i_val = req_val[g]; adder_i_data = req_data[g]; req_rdy[g] = adder_i_rdy; other req_rdy bits = 0.
  - adder_i_val must be 0 outside SEND: the adder latches data whenever its val is high.
  - If req_val[g] and adder_i_rdy are both high, the handshake completes: go to WAIT.
  - If req_val[g] drops before the handshake, return to IDLE with rr_ptr unchanged; no transaction is counted.
- WAIT:
  - resp_val[g] = adder_o_val; resp_data = adder_o_data; adder_o_rdy = resp_rdy[g]; all other resp_val and req_rdy bits = 0.
  - On adder_o_val and resp_rdy[g]: rr_ptr = (g+1) mod NUM_REQ, done_count increments, go to IDLE.
  - done_count wraps from all-ones to 0.
  - Backpressure is unbounded: stay in WAIT with resp_val held until resp_rdy[g] is asserted.
- Latency and throughput:
  - With the adder and resp_rdy always high: request accepted in the cycle after the grant cycle, response in the next cycle, IDLE in the cycle after that.
  - Peak throughput is one transaction per 3 cycles.
- Simultaneous requests: only the granted requester sees req_rdy. The others hold their val and wait.
- Fairness: a requester continuously requesting waits at most NUM_REQ-1 transactions.
- Arithmetic: the arbiter never modifies data. resp_data equals req_data+1 mod 2^DATA_W, as computed by the adder.

Test Plan:
- Single request: req_val[2]=1, req_data[2]=0x0000_0010, resp_rdy=all 1 -> grant_id=2; resp_val[2]=1 with resp_data=0x11 exactly 2 cycles after the IDLE grant cycle; done_count=1; busy back to 0.
- All four requesting from reset, data i*0x100 -> service order 0,1,2,3,0; responses 0x001, 0x101, 0x201, 0x301; one completion every 3 cycles.
- Wrap-around: req_data[1]=0xFFFF_FFFF -> resp_data=0x0000_0000. Only req 3 and 0 asserted, rr_ptr=2 -> req 3 is granted first, then 0.
- Backpressure: resp_rdy[0]=0 for 5 cycles in WAIT -> resp_val[0] held high, resp_data stable, no other req_rdy asserted, done_count unchanged; released -> completes.
- Withdrawal: req_val[1] dropped in SEND while adder_i_rdy=1 is withheld (adder stub) -> return to IDLE, rr_ptr unchanged, done_count unchanged.
- Reset mid-WAIT: assert reset for 1 cycle -> next cycle state IDLE, all val/rdy outputs 0, grant_id=0, done_count=0; a subsequent request completes normally.

Source files
------------

// File: rtl/adder_rr_arbiter_if.sv
// rtl/adder_rr_arbiter_if.sv - requester and adder stream signals shared by the arbiter
interface adder_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_val;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        resp_val;
    logic [NUM_REQ-1:0]        resp_rdy;
    logic [DATA_W-1:0]         resp_data;
    logic                      adder_i_val;
    logic                      adder_i_rdy;
    logic [DATA_W-1:0]         adder_i_data;
    logic                      adder_o_val;
    logic                      adder_o_rdy;
    logic [DATA_W-1:0]         adder_o_data;

    // Arbiter side
    modport slave (
        input  req_val, req_data, resp_rdy, adder_i_rdy, adder_o_val, adder_o_data,
        output req_rdy, resp_val, resp_data, adder_i_val, adder_i_data, adder_o_rdy
    );

    // Requester and adder side
    modport master (
        output req_val, req_data, resp_rdy, adder_i_rdy, adder_o_val, adder_o_data,
        input  req_rdy, resp_val, resp_data, adder_i_val, adder_i_data, adder_o_rdy
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one +1 adder stream among NUM_REQ requesters
module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    adder_rr_arbiter_if.slave    bus,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  done_q, done_d;

    logic [DATA_W-1:0] req_words [NUM_REQ];
    logic              scan_found;
    logic [ID_W-1:0]   scan_idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!scan_found && bus.req_val[idx]) begin
                scan_found = 1'b1;
                scan_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = done_q;

        bus.req_rdy      = '0;
        bus.resp_val     = '0;
        bus.resp_data    = bus.adder_o_data;
        bus.adder_i_val  = 1'b0;
        bus.adder_i_data = '0;
        bus.adder_o_rdy  = 1'b0;

        // Outputs stay quiet during reset even though state only clears at the edge
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (scan_found) begin
                        grant_d = scan_idx;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    bus.adder_i_val       = bus.req_val[grant_q];
                    bus.adder_i_data      = req_words[grant_q];
                    bus.req_rdy[grant_q]  = bus.adder_i_rdy;
                    if (bus.req_val[grant_q] && bus.adder_i_rdy) begin
                        state_d = WAIT;
                    end else if (!bus.req_val[grant_q]) begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    bus.resp_val[grant_q] = bus.adder_o_val;
                    bus.adder_o_rdy       = bus.resp_rdy[grant_q];
                    if (bus.adder_o_val && bus.resp_rdy[grant_q]) begin
                        rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                        done_d   = done_q + 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed bench for adder_rr_arbiter with a +1 adder stub
module tb_adder_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        grant_id;
    logic              busy;
    logic [CNT_W-1:0]  done_count;

    logic              a_full;
    logic [DATA_W-1:0] a_data;
    logic              adder_hold;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;

    adder_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus_if ();

    adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .grant_id   (grant_id),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // One-deep +1 adder: accepts when empty, result valid the cycle after acceptance
    assign bus_if.adder_i_rdy  = !a_full && !adder_hold;
    assign bus_if.adder_o_val  = a_full;
    assign bus_if.adder_o_data = a_data;

    always @(posedge clk) begin
        if (reset) begin
            a_full <= 1'b0;
            a_data <= '0;
        end else if (bus_if.adder_i_val && bus_if.adder_i_rdy) begin
            a_full <= 1'b1;
            a_data <= bus_if.adder_i_data + 1;
        end else if (bus_if.adder_o_val && bus_if.adder_o_rdy) begin
            a_full <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        bus_if.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        adder_hold        = 1'b0;
        bus_if.req_val    = '0;
        bus_if.req_data   = '0;
        bus_if.resp_rdy   = '1;
        tick();
        tick();
        #1;
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_grant",    64'(grant_id), 64'd0);
        chk("rst_done",     64'(done_count), 64'd0);
        chk("rst_req_rdy",  64'(bus_if.req_rdy), 64'd0);
        chk("rst_i_val",    64'(bus_if.adder_i_val), 64'd0);
        chk("rst_i_data",   64'(bus_if.adder_i_data), 64'd0);
        chk("rst_o_rdy",    64'(bus_if.adder_o_rdy), 64'd0);
        reset = 1'b0;
        tick();

        // Single request from requester 2
        bus_if.req_val = 4'b0100;
        set_data(2, 32'h0000_0010);
        #1;
        chk("s_idle_rdy", 64'(bus_if.req_rdy), 64'd0);
        chk("s_idle_ival", 64'(bus_if.adder_i_val), 64'd0);
        tick();
        chk("s_grant",   64'(grant_id), 64'd2);
        chk("s_busy",    64'(busy), 64'd1);
        chk("s_ival",    64'(bus_if.adder_i_val), 64'd1);
        chk("s_idata",   64'(bus_if.adder_i_data), 64'h10);
        chk("s_req_rdy", 64'(bus_if.req_rdy), 64'b0100);
        tick();
        bus_if.req_val = '0;
        #1;
        chk("s_resp_val",  64'(bus_if.resp_val), 64'b0100);
        chk("s_resp_data", 64'(bus_if.resp_data), 64'h11);
        chk("s_ival_wait", 64'(bus_if.adder_i_val), 64'd0);
        tick();
        chk("s_done",  64'(done_count), 64'd1);
        chk("s_idle",  64'(busy), 64'd0);
        chk("s_rv0",   64'(bus_if.resp_val), 64'd0);

        // All four requesting after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 32'(i * 32'h100));
        bus_if.req_val = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_grant",   64'(grant_id), 64'(n % 4));
            chk("rr_req_rdy", 64'(bus_if.req_rdy), 64'(1 << (n % 4)));
            tick();
            chk("rr_resp_val",  64'(bus_if.resp_val), 64'(1 << (n % 4)));
            chk("rr_resp_data", 64'(bus_if.resp_data), 64'((n % 4) * 32'h100 + 1));
            tick();
            chk("rr_done", 64'(done_count), 64'(n + 1));
        end
        bus_if.req_val = '0;

        // Data wrap on requester 1 (rr_ptr is 1 here)
        set_data(1, 32'hFFFF_FFFF);
        bus_if.req_val = 4'b0010;
        tick();
        chk("wr_grant", 64'(grant_id), 64'd1);
        tick();
        bus_if.req_val = '0;
        #1;
        chk("wr_resp_val",  64'(bus_if.resp_val), 64'b0010);
        chk("wr_resp_data", 64'(bus_if.resp_data), 64'd0);
        tick();
        chk("wr_done", 64'(done_count), 64'd6);

        // rr_ptr = 2 with only 3 and 0 requesting: 3 first, then 0
        bus_if.req_val = 4'b1001;
        tick();
        chk("p3_grant", 64'(grant_id), 64'd3);
        tick();
        bus_if.req_val = 4'b0001;
        #1;
        chk("p3_resp_data", 64'(bus_if.resp_data), 64'h301);
        tick();
        chk("p3_done", 64'(done_count), 64'd7);
        tick();
        chk("p0_grant", 64'(grant_id), 64'd0);
        tick();

        // Backpressure on requester 0 with requester 1 waiting
        bus_if.resp_rdy = 4'b1110;
        bus_if.req_val  = 4'b0010;
        set_data(1, 32'h0000_0005);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_resp_val",  64'(bus_if.resp_val), 64'b0001);
            chk("bp_resp_data", 64'(bus_if.resp_data), 64'h1);
            chk("bp_req_rdy",   64'(bus_if.req_rdy), 64'd0);
            chk("bp_done",      64'(done_count), 64'd7);
            tick();
        end
        bus_if.resp_rdy = '1;
        bus_if.req_val  = '0;
        tick();
        chk("bp_release_done", 64'(done_count), 64'd8);
        chk("bp_release_busy", 64'(busy), 64'd0);

        // Withdrawal in SEND while the adder withholds ready (rr_ptr = 1)
        adder_hold     = 1'b1;
        bus_if.req_val = 4'b0010;
        tick();
        chk("wd_grant",   64'(grant_id), 64'd1);
        chk("wd_ival",    64'(bus_if.adder_i_val), 64'd1);
        chk("wd_req_rdy", 64'(bus_if.req_rdy), 64'd0);
        tick();
        chk("wd_still_send", 64'(busy), 64'd1);
        bus_if.req_val = '0;
        tick();
        chk("wd_idle", 64'(busy), 64'd0);
        chk("wd_done", 64'(done_count), 64'd8);
        adder_hold     = 1'b0;
        bus_if.req_val = 4'b0110;
        tick();
        chk("wd_ptr_kept", 64'(grant_id), 64'd1);
        tick();
        chk("wd_resp_data", 64'(bus_if.resp_data), 64'h6);

        // Reset while in WAIT
        reset = 1'b1;
        #1;
        chk("rw_resp_val_in_rst", 64'(bus_if.resp_val), 64'd0);
        chk("rw_o_rdy_in_rst",    64'(bus_if.adder_o_rdy), 64'd0);
        tick();
        reset          = 1'b0;
        bus_if.req_val = '0;
        #1;
        chk("rw_busy",    64'(busy), 64'd0);
        chk("rw_grant",   64'(grant_id), 64'd0);
        chk("rw_done",    64'(done_count), 64'd0);
        chk("rw_resp_val", 64'(bus_if.resp_val), 64'd0);
        chk("rw_req_rdy",  64'(bus_if.req_rdy), 64'd0);
        chk("rw_ival",     64'(bus_if.adder_i_val), 64'd0);
        bus_if.req_val = 4'b0100;
        set_data(2, 32'h0000_0010);
        tick();
        chk("rw2_grant", 64'(grant_id), 64'd2);
        tick();
        bus_if.req_val = '0;
        #1;
        chk("rw2_resp_data", 64'(bus_if.resp_data), 64'h11);
        tick();
        chk("rw2_done", 64'(done_count), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
